// File: rtl/bp_pkg.sv
// Shared branch-prediction types and constants for the fetch-stage predictors.
package bp_pkg;

  localparam int BTB_INDEX_DEF = 6;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } pred_t;

endpackage

// File: rtl/btb_next_pc_if.sv
// Fetch/EX handshake bundle between the pipeline and the BTB next-PC block.
interface btb_next_pc_if;

  logic        i_stall;
  logic [31:0] i_pc_if;
  logic        i_gshare_predict;
  logic        i_ex_update;
  logic [31:0] i_ex_pc;
  logic        i_ex_taken;
  logic [31:0] i_ex_target;
  logic [31:0] o_next_pc;
  logic        o_pred_taken;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic        o_flush;

  modport master (
    output i_stall, i_pc_if, i_gshare_predict, i_ex_update, i_ex_pc, i_ex_taken, i_ex_target,
    input  o_next_pc, o_pred_taken, o_mispredict, o_redirect_pc, o_flush
  );

  modport slave (
    input  i_stall, i_pc_if, i_gshare_predict, i_ex_update, i_ex_pc, i_ex_taken, i_ex_target,
    output o_next_pc, o_pred_taken, o_mispredict, o_redirect_pc, o_flush
  );

endinterface

// File: rtl/btb_next_pc_table.sv
// Direct-mapped BTB array: async-cleared valid bits, combinational read, synchronous write.
module btb_table #(
  parameter int BTB_INDEX = 6,
  parameter int TAG_W     = 30 - BTB_INDEX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BTB_INDEX-1:0] rd_idx,
  input  logic [TAG_W-1:0]     rd_tag,
  output logic                 rd_hit,
  output logic [29:0]          rd_target,
  input  logic                 wr_en,
  input  logic [BTB_INDEX-1:0] wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [29:0]          wr_target
);

  localparam int ENTRIES = 1 << BTB_INDEX;

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [29:0]        target_r [ENTRIES];

  // Valid bits: only these are reset, so a reset invalidates every entry at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag/target storage, meaningless until the matching valid bit is set
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx]    <= wr_tag;
      target_r[wr_idx] <= wr_target;
    end
  end

  // Read port sees pre-write contents when indices collide in one cycle
  always_comb begin
    rd_hit    = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
    rd_target = target_r[rd_idx];
  end

endmodule

// File: rtl/btb_next_pc.sv
// BTB-based next-PC selection with IF->ID->EX prediction tracking and EX mispredict detection.
module btb_next_pc
  import bp_pkg::*;
#(
  parameter int BTB_INDEX = BTB_INDEX_DEF,
  parameter int TAG_W     = 30 - BTB_INDEX
) (
  input  logic         clk,
  input  logic         rst,
  btb_next_pc_if.slave bus
);

  logic        btb_hit_s;
  logic [29:0] btb_word_s;
  logic [31:0] pred_target_s;
  logic        pred_taken_s;
  logic        wr_en_s;
  logic        mispredict_s;
  logic [31:0] redirect_s;
  logic [31:0] next_pc_s;
  pred_t       pid_r;
  pred_t       pex_r;

  btb_table #(
    .BTB_INDEX (BTB_INDEX),
    .TAG_W     (TAG_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bus.i_pc_if[BTB_INDEX+1:2]),
    .rd_tag    (bus.i_pc_if[31:BTB_INDEX+2]),
    .rd_hit    (btb_hit_s),
    .rd_target (btb_word_s),
    .wr_en     (wr_en_s),
    .wr_idx    (bus.i_ex_pc[BTB_INDEX+1:2]),
    .wr_tag    (bus.i_ex_pc[31:BTB_INDEX+2]),
    .wr_target (bus.i_ex_target[31:2])
  );

  // IF prediction, BTB allocation on aligned taken resolutions, EX compare and next-PC mux
  always_comb begin
    pred_target_s = {btb_word_s, 2'b00};
    pred_taken_s  = btb_hit_s & bus.i_gshare_predict;
    wr_en_s       = bus.i_ex_update & bus.i_ex_taken & (bus.i_ex_pc[1:0] == 2'b00);
    redirect_s    = bus.i_ex_taken ? bus.i_ex_target : (bus.i_ex_pc + PC_INC);
    mispredict_s  = 1'b0;
    if (bus.i_ex_update) begin
      mispredict_s = (pex_r.taken != bus.i_ex_taken) |
                     (bus.i_ex_taken & pex_r.taken & (pex_r.target != bus.i_ex_target));
    end else begin
      mispredict_s = 1'b0;
    end
    next_pc_s = bus.i_pc_if + PC_INC;
    if (mispredict_s) begin
      next_pc_s = redirect_s;
    end else if (pred_taken_s) begin
      next_pc_s = pred_target_s;
    end else begin
      next_pc_s = bus.i_pc_if + PC_INC;
    end
  end

  // Prediction pipeline: flush beats stall so a redirect always kills younger predictions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pid_r <= '{taken: 1'b0, target: 32'd0};
      pex_r <= '{taken: 1'b0, target: 32'd0};
    end else if (mispredict_s) begin
      pid_r <= '{taken: 1'b0, target: 32'd0};
      pex_r <= '{taken: 1'b0, target: 32'd0};
    end else if (!bus.i_stall) begin
      pid_r <= '{taken: pred_taken_s, target: pred_target_s};
      pex_r <= pid_r;
    end else begin
      pid_r <= pid_r;
      pex_r <= pex_r;
    end
  end

  assign bus.o_next_pc     = next_pc_s;
  assign bus.o_pred_taken  = pred_taken_s;
  assign bus.o_mispredict  = mispredict_s;
  assign bus.o_redirect_pc = redirect_s;
  assign bus.o_flush       = mispredict_s;

endmodule

// File: tb/tb_btb_next_pc.sv
// Directed scoreboard bench for btb_next_pc: BTB fill/alias, mispredict/flush, stall hold, async reset.
module tb_btb_next_pc;

  logic clk;
  logic rst;

  btb_next_pc_if bus ();

  btb_next_pc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic drive(input logic upd, input logic [31:0] epc, input logic tk,
                       input logic [31:0] tgt, input logic [31:0] pc, input logic g,
                       input logic st);
    bus.i_ex_update      = upd;
    bus.i_ex_pc          = epc;
    bus.i_ex_taken       = tk;
    bus.i_ex_target      = tgt;
    bus.i_pc_if          = pc;
    bus.i_gshare_predict = g;
    bus.i_stall          = st;
  endtask

  // Push expectations for the current inputs, let logic settle, then pop against outputs
  task automatic chk(input string tag, input logic pt, input logic [31:0] np,
                     input logic mp, input logic rd_en, input logic [31:0] rd);
    push({tag, ".pred_taken"}, {31'd0, pt});
    push({tag, ".next_pc"}, np);
    push({tag, ".mispredict"}, {31'd0, mp});
    push({tag, ".flush"}, {31'd0, mp});
    if (rd_en) push({tag, ".redirect_pc"}, rd);
    #2;
    pop_cmp({31'd0, bus.o_pred_taken});
    pop_cmp(bus.o_next_pc);
    pop_cmp({31'd0, bus.o_mispredict});
    pop_cmp({31'd0, bus.o_flush});
    if (rd_en) pop_cmp(bus.o_redirect_pc);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1, 1'b0);
    chk("rst", 1'b0, 32'h104, 1'b0, 1'b0, 32'h0);
    next_cycle();
    rst = 1'b0;
    chk("post_rst", 1'b0, 32'h104, 1'b0, 1'b0, 32'h0);

    // First taken resolution: lookup in the same cycle still misses
    next_cycle();
    drive(1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b1, 1'b0);
    chk("wr_same_cycle", 1'b0, 32'h200, 1'b1, 1'b1, 32'h200);

    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1, 1'b0);
    chk("hit", 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b0, 1'b0);
    chk("hit_gshare0", 1'b0, 32'h104, 1'b0, 1'b0, 32'h0);

    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h1100, 1'b1, 1'b0);
    chk("alias", 1'b0, 32'h1104, 1'b0, 1'b0, 32'h0);

    // Predict taken, resolve not-taken two cycles later, then confirm flush cleared pid/pex
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1, 1'b0);
    chk("pred_a", 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h500, 1'b0, 1'b0);
    chk("pred_b", 1'b0, 32'h504, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 32'h100, 1'b1, 1'b0);
    chk("mp_not_taken", 1'b1, 32'h104, 1'b1, 1'b1, 32'h104);
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 32'h600, 1'b0, 1'b0);
    chk("pex_cleared", 1'b0, 32'h604, 1'b0, 1'b1, 32'h104);
    next_cycle();
    chk("pid_cleared", 1'b0, 32'h604, 1'b0, 1'b1, 32'h104);

    // Taken to a new target: mispredict on target and BTB retarget
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1, 1'b0);
    chk("pred_f", 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h700, 1'b0, 1'b0);
    chk("pred_g", 1'b0, 32'h704, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 32'h100, 1'b1, 32'h300, 32'h100, 1'b1, 1'b0);
    chk("mp_target", 1'b1, 32'h300, 1'b1, 1'b1, 32'h300);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1, 1'b0);
    chk("new_target", 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);

    // Misaligned resolution: compared but must not overwrite the 0x100 entry
    next_cycle();
    drive(1'b1, 32'h102, 1'b1, 32'h400, 32'h800, 1'b0, 1'b0);
    chk("misaligned", 1'b0, 32'h400, 1'b1, 1'b1, 32'h400);
    next_cycle();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h100, 1'b1, 1'b0);
    chk("wrap_no_write", 1'b1, 32'h300, 1'b0, 1'b1, 32'h0);

    // Load pex with {1,0x300}, then stall three cycles
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h900, 1'b0, 1'b0);
    chk("pre_stall", 1'b0, 32'h904, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h900, 1'b0, 1'b1);
      chk("stall", 1'b0, 32'h904, 1'b0, 1'b0, 32'h0);
    end
    next_cycle();
    drive(1'b1, 32'h100, 1'b1, 32'h300, 32'h900, 1'b0, 1'b1);
    chk("stall_hold", 1'b0, 32'h904, 1'b0, 1'b1, 32'h300);
    drive(1'b1, 32'h100, 1'b1, 32'h304, 32'h900, 1'b0, 1'b1);
    chk("stall_override", 1'b0, 32'h304, 1'b1, 1'b1, 32'h304);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1, 1'b1);
    chk("stall_hit", 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);

    // Reset between clock edges clears table and pipeline at once
    rst = 1'b1;
    drive(1'b1, 32'h100, 1'b0, 32'h0, 32'h100, 1'b1, 1'b1);
    chk("rst_async", 1'b0, 32'h104, 1'b0, 1'b1, 32'h104);

    next_cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1, 1'b0);
    chk("final", 1'b0, 32'h104, 1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_next_pc.md
Name: btb_next_pc

Overview:
- Fetch-stage companion to the gshare direction predictor.
- Holds a direct-mapped Branch Target Buffer (BTB) and combines a BTB hit with the gshare taken bit to choose the next fetch PC.
- Carries each prediction through IF->ID->EX pipeline registers.
- In EX, compares the prediction against the resolved outcome and raises mispredict, redirect and flush.

Parameters:
- BTB_INDEX, 6, log2 of BTB entry count (64 entries); index = pc[BTB_INDEX+1:2].
- TAG_W, 30-BTB_INDEX, tag width; tag = pc[31:BTB_INDEX+2].

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- i_stall  input  1  pipeline hold; prediction registers keep their value.
- i_pc_if  input  32  current fetch PC.
- i_gshare_predict  input  1  taken bit from the gshare predictor for i_pc_if.
- i_ex_update  input  1  EX holds a resolved B/J-type instruction.
- i_ex_pc  input  32  PC of the resolving instruction.
- i_ex_taken  input  1  actual direction.
- i_ex_target  input  32  actual taken target.
- o_next_pc  output  32  next fetch PC.
- o_pred_taken  output  1  IF prediction, = btb_hit & i_gshare_predict.
- o_mispredict  output  1  EX detected a wrong prediction.
- o_redirect_pc  output  32  correct PC after a mispredict.
- o_flush  output  1  kill the IF and ID instructions; equals o_mispredict.

Behaviour:
- BTB entry: valid(1), tag(TAG_W), target(30, word address).
- On reset, all valid bits clear asynchronously; tags and targets are not reset.
- Lookup is combinational. btb_hit = valid[idx] & (tag[idx] == i_pc_if tag field).
- Predicted target = {target[idx], 2'b00}.
- BTB write happens on the rising edge when i_ex_update & i_ex_taken & (i_ex_pc[1:0] == 2'b00). It sets valid, writes the tag, and writes i_ex_target[31:2].
- A not-taken resolution never evicts or changes an entry.
- i_ex_update with misaligned i_ex_pc:
  - Ignored for BTB writes.
  - Mispredict compare is still performed.
- Read/write to the same index in the same cycle: the lookup returns the pre-write contents; the new entry is visible on the next cycle.
- Prediction pipeline: two registers, pid then pex, each holding {taken, target[31:0]}.
  - Every clock: pid <= {o_pred_taken, pred_target}; pex <= pid.
  - Priority, highest first: rst, then o_flush, then i_stall.
  - rst or o_flush: pid and pex cleared to 0 (predict not-taken, target 0).
  - i_stall without flush: pid and pex hold.
- EX compare is combinational from pex and the EX inputs:
  - o_mispredict = i_ex_update & ((pex.taken != i_ex_taken) | (i_ex_taken & pex.taken & (pex.target != i_ex_target))).
  - o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4, computed modulo 2^32 (0xFFFFFFFC + 4 = 0).
  - o_mispredict is 0 whenever i_ex_update = 0, and o_redirect_pc is then don't-care.
- Next PC:
  - o_mispredict has highest priority: o_next_pc = o_redirect_pc.
  - Else if o_pred_taken: the BTB target.
  - Else: i_pc_if + 4.
  - The mispredict override also applies while i_stall = 1.
- Reset values:
  - o_mispredict = 0, o_flush = 0, o_pred_taken = 0 (all BTB entries invalid).
  - o_next_pc = i_pc_if + 4.
- Reset asserted mid-operation: the table is invalidated and the pipeline cleared immediately, without waiting for a clock edge.
- Latency:
  - Prediction to next PC: 0 cycles.
  - Prediction to EX compare: 2 cycles.
  - BTB write to visible hit: 1 cycle.

Decomposition:
- Shared package bp_pkg holds:
  - the BTB_INDEX default;
  - the PC_INC = 32'd4 constant;
  - a packed pred_t {taken, target} used by the pid/pex registers and reusable by the gshare pipeline.
- One sub-module: btb_table. It is the valid/tag/target array with async valid clear, a combinational read port and a synchronous write port.
- Next-PC mux and compare logic live in the top.

Test Plan:
- Reset, then i_pc_if = 0x100 with gshare = 1 -> o_pred_taken = 0, o_next_pc = 0x104.
- EX update pc = 0x100, taken, target = 0x200. Next cycle, i_pc_if = 0x100 and gshare = 1 -> hit, o_next_pc = 0x200. With gshare = 0 -> 0x104.
- Aliasing: write pc = 0x100; fetch pc = 0x1100 (same index, different tag) with gshare = 1 -> no hit, o_next_pc = 0x1104.
- Predict taken to 0x200 at IF. Two cycles later, EX update with pc = 0x100, taken = 0 -> o_mispredict = 1, o_redirect_pc = 0x104, o_next_pc = 0x104. The next cycle pid and pex are zero.
- Predicted taken, resolved taken to 0x300 -> mispredict, redirect 0x300, BTB target updated to 0x300. Fetching 0x100 next cycle -> 0x300.
- Hold i_stall for 3 cycles: pex is unchanged. Assert rst mid-stall -> o_pred_taken = 0 immediately, a previous hit no longer hits, and o_mispredict = 0.
